// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encodings, error codes and timing defaults
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_STOP   = 2'b10;

  // 1 ms at 100 MHz between mouse-clock falling edges inside a frame
  localparam int PS2_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/ps2_mouse_byte_receiver.sv
// rtl/ps2_mouse_byte_receiver.sv - deframes device-to-host PS/2 frames into bytes with error codes
module ps2_mouse_byte_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int CNT_W          = 17
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rx_state_t        r_state;
  logic [2:0]       r_bit_cnt;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_clk_prev;
  logic [7:0]       r_shift;
  logic             r_parity_err;

  logic             w_fe;
  logic             w_par_err;
  logic [1:0]       w_code;

  assign w_fe      = r_clk_prev & ~CLK_MOUSE_IN;
  assign w_par_err = ~(^r_shift ^ DATA_MOUSE_IN);
  assign w_code    = (r_parity_err   ? ERR_PARITY : ERR_NONE) |
                     (~DATA_MOUSE_IN ? ERR_STOP   : ERR_NONE);

  // Outputs are loaded on the stop-bit edge so they are already valid while DONE strobes READY.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state         <= IDLE;
      r_bit_cnt       <= 3'd0;
      r_to_cnt        <= '0;
      r_clk_prev      <= 1'b1;
      r_shift         <= 8'h00;
      r_parity_err    <= 1'b0;
      BYTE_READ       <= 8'h00;
      BYTE_ERROR_CODE <= ERR_NONE;
      BYTE_READY      <= 1'b0;
    end else begin
      r_clk_prev <= CLK_MOUSE_IN;
      BYTE_READY <= 1'b0;
      case (r_state)
        IDLE: begin
          r_to_cnt <= '0;
          if (w_fe && READ_ENABLE && !DATA_MOUSE_IN) begin
            r_state   <= DATA;
            r_bit_cnt <= 3'd0;
          end
        end
        DATA, PARITY, STOP: begin
          if (w_fe) begin
            r_to_cnt <= '0;
            if (r_state == DATA) begin
              r_shift <= {DATA_MOUSE_IN, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) begin
                r_bit_cnt <= 3'd0;
                r_state   <= PARITY;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end else if (r_state == PARITY) begin
              r_parity_err <= w_par_err;
              r_state      <= STOP;
            end else begin
              BYTE_READ       <= r_shift;
              BYTE_ERROR_CODE <= w_code;
              BYTE_READY      <= 1'b1;
              r_state         <= DONE;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt <= '0;
            r_state  <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        DONE: begin
          r_to_cnt <= '0;
          r_state  <= IDLE;
        end
        default: begin
          r_to_cnt <= '0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_byte_receiver.sv
// tb/tb_ps2_mouse_byte_receiver.sv - scoreboard bench for the PS/2 byte receiver
module tb_ps2_mouse_byte_receiver;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CLK_MOUSE_IN = 1'b1;
  logic       DATA_MOUSE_IN = 1'b1;
  logic       READ_ENABLE = 1'b1;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] c;
  } exp_t;

  exp_t exp_q[$];

  ps2_mouse_byte_receiver #(
    .TIMEOUT_CYCLES(200),
    .CNT_W(17)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .CLK_MOUSE_IN(CLK_MOUSE_IN),
    .DATA_MOUSE_IN(DATA_MOUSE_IN),
    .READ_ENABLE(READ_ENABLE),
    .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY(BYTE_READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_ready;
    prev_ready = 1'b0;
    forever begin
      @(negedge CLK);
      if (BYTE_READY === 1'b1) begin
        chk("strobe_single_cycle", {31'd0, prev_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("byte_read", {24'd0, BYTE_READ}, {24'd0, e.b});
          chk("byte_error_code", {30'd0, BYTE_ERROR_CODE}, {30'd0, e.c});
        end
      end
      prev_ready = BYTE_READY;
    end
  end

  // Sends the first nbits of {stop, parity, byte, start}; mouse clock period is 20 CLK cycles.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input logic en, input int nbits, input logic strobe);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    READ_ENABLE = en;
    for (int i = 0; i < nbits; i++) begin
      DATA_MOUSE_IN = f[i];
      repeat (5) @(negedge CLK);
      CLK_MOUSE_IN = 1'b0;
      if (i == 10) begin
        @(negedge CLK);
        chk("ready_latency", {31'd0, BYTE_READY}, {31'd0, strobe});
        @(negedge CLK);
        chk("ready_drop", {31'd0, BYTE_READY}, 32'd0);
        repeat (8) @(negedge CLK);
      end else begin
        repeat (10) @(negedge CLK);
      end
      CLK_MOUSE_IN = 1'b1;
      repeat (5) @(negedge CLK);
    end
    DATA_MOUSE_IN = 1'b1;
    READ_ENABLE = 1'b1;
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic [1:0] c);
    exp_t e;
    e.b = b;
    e.c = c;
    exp_q.push_back(e);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("reset_byte", {24'd0, BYTE_READ}, 32'h00);
    chk("reset_code", {30'd0, BYTE_ERROR_CODE}, 32'd0);
    chk("reset_ready", {31'd0, BYTE_READY}, 32'd0);

    expect_byte(8'hFA, 2'b00);
    send_frame(8'hFA, 1'b1, 1'b1, 1'b1, 11, 1'b1);
    expect_byte(8'hFA, 2'b01);
    send_frame(8'hFA, 1'b0, 1'b1, 1'b1, 11, 1'b1);
    expect_byte(8'h08, 2'b10);
    send_frame(8'h08, 1'b0, 1'b0, 1'b1, 11, 1'b1);

    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 11, 1'b0);
    chk("hold_byte_after_disabled", {24'd0, BYTE_READ}, 32'h08);
    chk("hold_code_after_disabled", {30'd0, BYTE_ERROR_CODE}, 32'd2);
    expect_byte(8'h3C, 2'b00);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 11, 1'b1);

    send_frame(8'h55, 1'b1, 1'b1, 1'b1, 5, 1'b0);
    repeat (250) @(negedge CLK);
    chk("hold_byte_after_timeout", {24'd0, BYTE_READ}, 32'h3C);
    expect_byte(8'h55, 2'b00);
    send_frame(8'h55, 1'b1, 1'b1, 1'b1, 11, 1'b1);

    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 6, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("midframe_reset_byte", {24'd0, BYTE_READ}, 32'h00);
    chk("midframe_reset_code", {30'd0, BYTE_ERROR_CODE}, 32'd0);
    chk("midframe_reset_ready", {31'd0, BYTE_READY}, 32'd0);
    expect_byte(8'hA5, 2'b00);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 11, 1'b1);

    expect_byte(8'h08, 2'b00);
    expect_byte(8'h01, 2'b00);
    expect_byte(8'hFF, 2'b00);
    send_frame(8'h08, 1'b0, 1'b1, 1'b1, 11, 1'b1);
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 11, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 11, 1'b1);

    repeat (5) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_byte_receiver.md
Name: ps2_mouse_byte_receiver

Overview:
- Device-to-host PS/2 byte receiver. Sits directly upstream of the mouse master state machine inside the mouse transceiver.
- Consumes the already-filtered mouse clock and the raw mouse data line. Deframes 11-bit PS/2 frames: start, 8 data bits LSB first, odd parity, stop.
- Delivers each received byte with an error code and a one-cycle ready strobe.
- Includes an inactivity timeout so that a truncated frame never wedges the link.

Parameters:
- TIMEOUT_CYCLES, 100000, maximum CLK cycles allowed between consecutive mouse-clock falling edges inside a frame (1 ms at 100 MHz).
- CNT_W, 17, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- CLK_MOUSE_IN  input  1  filtered (debounced) PS/2 clock level
- DATA_MOUSE_IN  input  1  PS/2 data line level
- READ_ENABLE  input  1  master permits a new frame to start
- BYTE_READ  output  8  last received data byte
- BYTE_ERROR_CODE  output  2  bit0 = parity error, bit1 = stop-bit error
- BYTE_READY  output  1  one-cycle strobe: byte and code are valid

Behaviour:
- Reset:
  - RESET is synchronous, active-high; clock is CLK.
  - On reset: BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00, BYTE_READY=0, state=IDLE, bit counter=0, timeout counter=0, previous-clock register=1.
- Edge detect:
  - Register CLK_MOUSE_IN every cycle.
  - A falling edge (fe) is asserted in the cycle where the previous value is 1 and the current value is 0.
  - DATA_MOUSE_IN is sampled in that same cycle.
- States: IDLE, DATA, PARITY, STOP, DONE.
  - IDLE: on fe with READ_ENABLE=1 and data=0 (valid start bit), go to DATA and clear the bit counter. Otherwise (data=1 or READ_ENABLE=0) stay in IDLE.
  - DATA: on each fe, shift the sampled bit into shift_reg[7] (right shift, so LSB first lands at bit 0) and increment the counter. After the 8th bit, go to PARITY.
  - PARITY: on fe, latch the parity bit. parity_err = ~(^shift_reg ^ parity_bit), i.e. odd parity is required. Go to STOP.
  - STOP: on fe, latch stop_err = ~data. Go to DONE.
  - DONE: lasts exactly one cycle.
    - BYTE_READ <= shift_reg; BYTE_ERROR_CODE <= {stop_err, parity_err}.
    - BYTE_READY=1 during this cycle only.
    - Return to IDLE.
- Output timing and errors:
  - Latency from the stop-bit fe to BYTE_READY high is 1 cycle.
  - BYTE_READ and BYTE_ERROR_CODE hold their values until the next DONE.
  - A frame with errors still produces BYTE_READY. The master decides how to handle the byte.
- Timeout:
  - In DATA, PARITY or STOP, the counter increments every cycle and clears on each fe.
  - When the counter reaches TIMEOUT_CYCLES-1 with no fe, go to IDLE. No BYTE_READY, outputs unchanged, counter cleared.
  - The counter is held at 0 in IDLE and DONE.
- READ_ENABLE is sampled only at the start bit. Deasserting it mid-frame does not abort the frame.
- RESET mid-frame abandons the partial byte immediately. The next valid start bit begins a fresh frame.
- Simultaneous fe and timeout terminal count: fe wins (frame continues).
- The bit counter wraps only via the state change. It never exceeds 7.

Decomposition:
- Shared package ps2_pkg holds:
  - rx_state_t enum {IDLE, DATA, PARITY, STOP, DONE}
  - constants ERR_NONE=2'b00, ERR_PARITY=2'b01, ERR_STOP=2'b10
  - default PS2_TIMEOUT_CYCLES
- The falling-edge detector is inlined (three lines); no separate sub-module.
- The same package is reused by the companion transmitter for its own states.

Test Plan:
- Frame 0xFA (data bits 0,1,0,1,1,1,1,1, parity=1, stop=1) with READ_ENABLE=1 -> BYTE_READY pulses for exactly 1 cycle, 1 cycle after the stop fe; BYTE_READ=8'hFA; BYTE_ERROR_CODE=2'b00.
- Frame 0xFA with parity=0 -> BYTE_READ=8'hFA, code=2'b01. Frame 0x08 with parity=0 and stop=0 -> code=2'b10.
- Frame 0x3C started while READ_ENABLE=0 -> no BYTE_READY; outputs keep their previous values. The following frame 0x3C with READ_ENABLE=1 is received correctly with code 00.
- TIMEOUT_CYCLES=200: stop mouse clock edges after 4 data bits, wait 250 cycles, then send full frame 0x55 -> no strobe for the partial frame; 0x55 is received with code 00.
- RESET asserted for 1 cycle after the 5th data bit, then frame 0xA5 is sent -> all outputs are 0 after reset; BYTE_READ=8'hA5 and code 00 on a single strobe.
- Back-to-back frames 0x08, 0x01, 0xFF (parity 0, 0, 1) with minimal idle time between them -> three strobes in order, with the correct bytes and code 00 each time.
